// File: rtl/ctrl_ramdrv_coefseq_pkg.sv
// Shared definitions for the coefficient-RAM address sequencer:
// FSM state encoding, default parameter values and a width helper.
package ctrl_ramdrv_coefseq_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_STEP_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ctrl_ramdrv_coefcfg.sv
// Per-channel coefficient window configuration: base address, tap count
// and stride. One synchronous write port, one combinational read port.
// Out-of-range channel indices are ignored on write and read back as zero.
module ctrl_ramdrv_coefcfg
  import ctrl_ramdrv_coefseq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  localparam int CH_WIDTH  = ch_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CH_WIDTH-1:0]   wr_ch,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic [STEP_WIDTH-1:0] wr_step,
  input  logic [CH_WIDTH-1:0]   rd_ch,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic [LEN_WIDTH-1:0]  rd_len,
  output logic [STEP_WIDTH-1:0] rd_step
);

  logic [ADDR_WIDTH-1:0] base_mem [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_mem  [NUM_CH];
  logic [STEP_WIDTH-1:0] step_mem [NUM_CH];

  logic [31:0] wr_ch_ext;
  logic [31:0] rd_ch_ext;
  logic        wr_ok;
  logic        rd_ok;

  // Range checks done at 32 bits so non-power-of-two channel counts work.
  assign wr_ch_ext = 32'(wr_ch);
  assign rd_ch_ext = 32'(rd_ch);
  assign wr_ok     = wr_ch_ext < 32'(NUM_CH);
  assign rd_ok     = rd_ch_ext < 32'(NUM_CH);

  // Register file update: cleared on reset, written on a valid strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        base_mem[i] <= '0;
        len_mem[i]  <= '0;
        step_mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      base_mem[wr_ch] <= wr_base;
      len_mem[wr_ch]  <= wr_len;
      step_mem[wr_ch] <= wr_step;
    end
  end

  // Read port returns stored values, so a same-cycle write is not yet visible.
  always_comb begin
    rd_base = '0;
    rd_len  = '0;
    rd_step = '0;
    if (rd_ok) begin
      rd_base = base_mem[rd_ch];
      rd_len  = len_mem[rd_ch];
      rd_step = step_mem[rd_ch];
    end
  end

endmodule

// File: rtl/ctrl_ramdrv_coefseq.sv
// Coefficient RAM address sequencer. Walks a circular window of len taps
// starting at start_phase with a fixed stride, emitting base + offset per
// granted cycle. Channel parameters are snapshotted at start so later
// configuration writes never disturb a running sequence.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a start on a valid channel
//   S_RUN  | issuing addresses; advances only when en is high
//   S_DONE | one-cycle completion pulse (normal end, abort or len == 0)
module ctrl_ramdrv_coefseq
  import ctrl_ramdrv_coefseq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  localparam int CH_WIDTH  = ch_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_WIDTH-1:0]   cfg_ch,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [STEP_WIDTH-1:0] cfg_step,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   start_ch,
  input  logic [LEN_WIDTH-1:0]  start_phase,
  input  logic                  en,
  input  logic                  abort,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic                  addr_vld,
  output logic                  last,
  output logic                  done,
  output logic                  cfg_err
);

  // Offset arithmetic is one bit wider than the window so offset + step
  // cannot overflow before the wrap subtraction.
  localparam int SUM_W = LEN_WIDTH + 1;

  seq_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  offset_q, offset_d;
  logic [LEN_WIDTH-1:0]  tap_cnt_q, tap_cnt_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [ADDR_WIDTH-1:0] rd_base;
  logic [LEN_WIDTH-1:0]  rd_len;
  logic [STEP_WIDTH-1:0] rd_step;

  logic [31:0]      start_ch_ext;
  logic             start_ok;
  logic             start_bad_cfg;
  logic [SUM_W-1:0] len_ext;
  logic [SUM_W-1:0] off_sum;
  logic [SUM_W-1:0] off_wrap;
  logic             final_tap;

  ctrl_ramdrv_coefcfg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_CH     (NUM_CH),
    .LEN_WIDTH  (LEN_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_cfg (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we),
    .wr_ch   (cfg_ch),
    .wr_base (cfg_base),
    .wr_len  (cfg_len),
    .wr_step (cfg_step),
    .rd_ch   (start_ch),
    .rd_base (rd_base),
    .rd_len  (rd_len),
    .rd_step (rd_step)
  );

  assign start_ch_ext  = 32'(start_ch);
  assign start_ok      = start && (start_ch_ext < 32'(NUM_CH));
  assign start_bad_cfg = (SUM_W'(rd_step) >= SUM_W'(rd_len)) || (start_phase >= rd_len);

  // Circular window step: a single conditional subtraction of len.
  assign len_ext   = SUM_W'(len_q);
  assign off_sum   = SUM_W'(offset_q) + SUM_W'(step_q);
  assign off_wrap  = (off_sum >= len_ext) ? (off_sum - len_ext) : off_sum;
  assign final_tap = (tap_cnt_q == (len_q - LEN_WIDTH'(1)));

  assign coef_addr = base_q + ADDR_WIDTH'(offset_q);
  assign cfg_err   = cfg_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot of channel parameters plus walk position and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      step_q    <= '0;
      offset_q  <= '0;
      tap_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      len_q     <= len_d;
      step_q    <= step_d;
      offset_q  <= offset_d;
      tap_cnt_q <= tap_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state, datapath updates and outputs.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    step_d    = step_q;
    offset_d  = offset_q;
    tap_cnt_d = tap_cnt_q;
    cfg_err_d = cfg_err_q;
    busy      = 1'b0;
    addr_vld  = 1'b0;
    last      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          base_d    = rd_base;
          len_d     = rd_len;
          step_d    = rd_step;
          offset_d  = start_phase;
          tap_cnt_d = '0;
          if (start_bad_cfg) begin
            cfg_err_d = 1'b1;
          end
          state_d = (rd_len == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        busy     = 1'b1;
        addr_vld = en;
        last     = en && final_tap;
        if (abort) begin
          state_d = S_DONE;
        end else if (en) begin
          offset_d  = off_wrap[LEN_WIDTH-1:0];
          tap_cnt_d = tap_cnt_q + LEN_WIDTH'(1);
          if (final_tap) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ctrl_ramdrv_coefseq.md
CTRL_RAMDRV_COEFSEQ -- requirements
Module: ctrl_ramdrv_coefseq

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, coefficient RAM address width.
REQ-002 Parameter NUM_CH, default 4, number of independent coefficient channels (filter banks); minimum 1.
REQ-003 Parameter LEN_WIDTH, default 8, width of per-channel tap count.
REQ-004 Parameter STEP_WIDTH, default 4, width of per-channel address stride (polyphase step).
REQ-005 Local constant CH_WIDTH = max(1, clog2(NUM_CH)).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 cfg_we  in  1  channel configuration write strobe.
REQ-009 cfg_ch  in  CH_WIDTH  channel index for configuration write.
REQ-010 cfg_base  in  ADDR_WIDTH  channel base address.
REQ-011 cfg_len  in  LEN_WIDTH  channel tap count (window length).
REQ-012 cfg_step  in  STEP_WIDTH  channel stride.
REQ-013 start  in  1  sequence start request, single cycle.
REQ-014 start_ch  in  CH_WIDTH  channel to sequence.
REQ-015 start_phase  in  LEN_WIDTH  initial offset inside window.
REQ-016 en  in  1  advance enable (RAM port grant); low stalls sequence.
REQ-017 abort  in  1  terminate running sequence.
REQ-018 busy  out  1  high outside IDLE.
REQ-019 coef_addr  out  ADDR_WIDTH  current coefficient address.
REQ-020 addr_vld  out  1  coef_addr valid and consumed this cycle.
REQ-021 last  out  1  marks final tap of sequence, qualified by addr_vld.
REQ-022 done  out  1  one-cycle completion pulse.
REQ-023 cfg_err  out  1  sticky error: sequence started with step >= len or phase >= len.

Function
REQ-024 Config table SHALL hold base/len/step per channel; write on cfg_we at cfg_ch, visible from next cycle; cfg_ch >= NUM_CH ignored.
REQ-025 FSM states SHALL be IDLE, RUN, DONE.
REQ-026 IDLE + start: latch channel's base/len/step and offset = start_phase, tap_cnt = 0, go RUN; start outside IDLE ignored.
REQ-027 start with len = 0 SHALL go directly to DONE, no addr_vld.
REQ-028 start_ch >= NUM_CH SHALL be ignored (stay IDLE).
REQ-029 cfg_we and start same cycle, same channel: sequence uses pre-write values.
REQ-030 Config writes during RUN SHALL NOT affect the running sequence.
REQ-031 coef_addr = base_q + offset_q, modulo 2^ADDR_WIDTH; addr_vld = (state==RUN) & en (combinational from registers).
REQ-032 First address valid the cycle after start is sampled (latency 1).
REQ-033 On addr_vld: tap_cnt += 1; offset_next = offset + step; if offset_next >= len then offset_next -= len (single subtraction, circular window).
REQ-034 en low in RUN SHALL freeze offset and tap_cnt; coef_addr held.
REQ-035 last = addr_vld & (tap_cnt == len-1); on that cycle go DONE.
REQ-036 DONE lasts one cycle with done=1, then IDLE; start in DONE ignored.
REQ-037 abort in RUN SHALL go to DONE next cycle without further addr_vld; abort has priority over en; abort in IDLE/DONE ignored.
REQ-038 step >= len or start_phase >= len: sequence runs per REQ-033 arithmetic, cfg_err set; cleared only by reset.
REQ-039 Internal sums SHALL be computed at LEN_WIDTH+1 bits; no overflow in offset arithmetic.

Reset
REQ-040 rst_n low SHALL force IDLE, busy=0, addr_vld=0, last=0, done=0, cfg_err=0, offset/tap_cnt/base_q=0 (coef_addr=0), all config entries zero.
REQ-041 Reset mid-RUN SHALL terminate without done pulse; takes priority over all inputs.

Structure
REQ-042 Shared package SHALL contain FSM state encoding and default parameter constants.
REQ-043 Config table SHALL be sub-module ctrl_ramdrv_coefcfg (NUM_CH-entry register file, one write port, one read port).

Verification
REQ-044 Ch0 base=0x100 len=4 step=1, start phase=0 -> addrs 0x100,0x101,0x102,0x103 on 4 consecutive cycles, last on 0x103, done next cycle.
REQ-045 Ch2 base=0x200 len=5 step=2 phase=3 -> 0x203,0x200,0x202,0x204,0x201; cfg_err=0.
REQ-046 Ch1 len=3, en low cycles 2-3 -> address held, addr_vld low, total 3 valid addresses, done after 5 RUN cycles.
REQ-047 abort on second valid address of len=8 run -> no further addr_vld, done next cycle, busy low after.
REQ-048 base=0xFFE len=4 step=1 -> 0xFFE,0xFFF,0x000,0x001 (address wrap); len=0 start -> done 1 cycle later, no addr_vld.
REQ-049 rst_n low mid-RUN -> all outputs 0 next cycle, no done; step=4 len=4 start -> cfg_err=1 stays until reset.
